// File: rtl/result_p2s_pkg.sv
// Shared constants and types for the result_p2s output stage.
// Widths, rounding offset and the serializer FSM state encoding.
package result_p2s_pkg;

    // Product width coming out of the multiplier.
    localparam int P_IN_W  = 40;
    // Width of each serialized word.
    localparam int P_OUT_W = 24;
    // LSBs removed by rounding; P_IN_W - P_DROP must equal P_OUT_W.
    localparam int P_DROP  = 16;

    // Half an output LSB, added before truncation (round-half-up).
    localparam logic [P_IN_W:0] P_RND_OFS =
        (P_IN_W + 1)'(1) << (P_DROP - 1);

    // Bit counter width for the serializer.
    localparam int P_CNT_W = $clog2(P_OUT_W);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Offset for an arbitrary DROP, for parameterized users.
    function automatic logic [63:0] rnd_ofs(input int drop);
        return 64'(1) << (drop - 1);
    endfunction

endpackage

// File: rtl/result_p2s_round_sat.sv
// round_sat: combinational round-half-up of an IN_W product to OUT_W bits.
// Ports: y_i (product), r_o (rounded word), sat_o (word clamped to all ones).
module round_sat
    import result_p2s_pkg::*;
#(
    parameter int IN_W  = P_IN_W,
    parameter int OUT_W = P_OUT_W,
    parameter int DROP  = P_DROP
) (
    input  logic [IN_W-1:0]  y_i,
    output logic [OUT_W-1:0] r_o,
    output logic             sat_o
);

    localparam logic [IN_W:0] OFS = (IN_W + 1)'(rnd_ofs(DROP));

    // One extra bit so the carry out of the top is observable.
    logic [IN_W:0] sum;

    assign sum = {1'b0, y_i} + OFS;

    // A carry into bit IN_W means the rounded value no longer fits.
    assign sat_o = sum[IN_W];
    assign r_o   = sat_o ? {OUT_W{1'b1}} : sum[IN_W-1:DROP];

    // The fractional bits are discarded by design.
    logic unused_frac;
    assign unused_frac = ^sum[DROP-1:0];

endmodule

// File: rtl/result_p2s.sv
// result_p2s: rounds 40-bit products, buffers one word, serializes MSB-first.
// Ports: clk, rst (sync, active high); y_in/y_valid/y_ready producer side;
//        sout, sframe, sfirst, sdone, ssat framed serial output.
module result_p2s
    import result_p2s_pkg::*;
#(
    parameter int IN_W  = P_IN_W,
    parameter int OUT_W = P_OUT_W,
    parameter int DROP  = P_DROP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] y_in,
    input  logic            y_valid,
    output logic            y_ready,
    output logic            sout,
    output logic            sframe,
    output logic            sfirst,
    output logic            sdone,
    output logic            ssat
);

    localparam int CNT_W = $clog2(OUT_W);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Rounder output for the word currently on y_in.
    logic [OUT_W-1:0] rs_word;
    logic             rs_sat;

    round_sat #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .DROP  (DROP)
    ) u_round_sat (
        .y_i   (y_in),
        .r_o   (rs_word),
        .sat_o (rs_sat)
    );

    // Holding buffer.
    logic             hold_full_q;
    logic             hold_full_d;
    logic [OUT_W-1:0] hold_word_q;
    logic [OUT_W-1:0] hold_word_d;
    logic             hold_sat_q;
    logic             hold_sat_d;

    // Serializer.
    state_t           state_q;
    logic [OUT_W-1:0] shreg_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;

    logic capture;
    logic unload;
    logic in_shift;

    assign y_ready  = !hold_full_q;
    assign capture  = y_valid && y_ready;
    assign in_shift = (state_q == SHIFT);

    // The shifter takes the buffered word when idle, or on the last bit
    // of the current word so the next frame follows without a gap.
    assign unload = hold_full_q &&
                    ((state_q == IDLE) || (cnt_q == '0));

    // A capture on the same edge as an unload wins: the buffer stays full
    // with the new word.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_word_d = hold_word_q;
        hold_sat_d  = hold_sat_q;
        if (unload) begin
            hold_full_d = 1'b0;
        end
        if (capture) begin
            hold_full_d = 1'b1;
            hold_word_d = rs_word;
            hold_sat_d  = rs_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_q <= 1'b0;
            hold_word_q <= '0;
            hold_sat_q  <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_word_q <= hold_word_d;
            hold_sat_q  <= hold_sat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hold_full_q) begin
                        state_q <= SHIFT;
                        shreg_q <= hold_word_q;
                        sat_q   <= hold_sat_q;
                        cnt_q   <= CNT_TOP;
                    end
                end
                SHIFT: begin
                    if (cnt_q != '0) begin
                        shreg_q <= shreg_q << 1;
                        cnt_q   <= cnt_q - CNT_ONE;
                    end else if (hold_full_q) begin
                        shreg_q <= hold_word_q;
                        sat_q   <= hold_sat_q;
                        cnt_q   <= CNT_TOP;
                    end else begin
                        state_q <= IDLE;
                        shreg_q <= '0;
                        sat_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // All serial outputs are forced low outside a frame.
    assign sout   = in_shift && shreg_q[OUT_W-1];
    assign sframe = in_shift;
    assign sfirst = in_shift && (cnt_q == CNT_TOP);
    assign sdone  = in_shift && (cnt_q == '0);
    assign ssat   = in_shift && sat_q;

endmodule

// File: tb/tb_result_p2s.sv
// Self-checking bench for result_p2s.
// Table-driven rounding vectors plus back-to-back, backpressure, reset, idle.
module tb_result_p2s;

    localparam int OUT_W = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] y_in;
    logic        y_valid;
    logic        y_ready;
    logic        sout;
    logic        sframe;
    logic        sfirst;
    logic        sdone;
    logic        ssat;

    result_p2s dut (
        .clk     (clk),
        .rst     (rst),
        .y_in    (y_in),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .sout    (sout),
        .sframe  (sframe),
        .sfirst  (sfirst),
        .sdone   (sdone),
        .ssat    (ssat)
    );

    initial forever #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string nm,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Serial receiver.
    typedef struct {
        logic [23:0] w;
        logic        sat;
        logic        bad;
        int          start;
        int          done;
    } rx_t;

    rx_t         rxq[$];
    int          rx_bitn  = 0;
    logic [23:0] rx_acc   = '0;
    logic        rx_sat0  = 1'b0;
    logic        rx_bad   = 1'b0;
    int          rx_start = 0;
    int          run      = 0;
    int          maxrun   = 0;
    int          aborted  = 0;
    int          idle_bad = 0;

    initial forever begin
        @(negedge clk);
        if (sframe === 1'b1) begin
            if (rx_bitn == 0) begin
                rx_sat0  = ssat;
                rx_start = cyc;
                rx_bad   = 1'b0;
            end
            if (sfirst !== (rx_bitn == 0)) rx_bad = 1'b1;
            if (sdone !== (rx_bitn == OUT_W - 1)) rx_bad = 1'b1;
            if (ssat !== rx_sat0) rx_bad = 1'b1;
            rx_acc = {rx_acc[22:0], sout};
            run++;
            if (run > maxrun) maxrun = run;
            if (rx_bitn == OUT_W - 1) begin
                rxq.push_back('{rx_acc, rx_sat0, rx_bad, rx_start, cyc});
                rx_bitn = 0;
            end else begin
                rx_bitn++;
            end
        end else begin
            run = 0;
            if (rx_bitn != 0) begin
                aborted++;
                rx_bitn = 0;
            end
            if (sout === 1'b1 || sfirst === 1'b1 ||
                sdone === 1'b1 || ssat === 1'b1)
                idle_bad++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [39:0] y, output int cap);
        int n;
        n = 0;
        y_in    = y;
        y_valid = 1'b1;
        while (!y_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("send_timeout", 64'(y_ready), 64'(1));
        tick();
        cap     = cyc;
        y_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rxq.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("rx_arrived", 64'(rxq.size() >= n), 64'(1));
    endtask

    typedef struct {
        logic [39:0] y;
        logic [23:0] w;
        logic        sat;
    } vec_t;

    vec_t vt[10];

    initial begin
        int   cap;
        int   k;
        int   ab0;
        int   idl0;
        int   nrx;
        rx_t  r;
        rx_t  r2;
        int   exp_q[$];

        vt[0] = '{40'h00_0001_8000, 24'h000002, 1'b0};
        vt[1] = '{40'hFF_FFFF_7FFF, 24'hFFFFFF, 1'b0};
        vt[2] = '{40'hFF_FFFF_8000, 24'hFFFFFF, 1'b1};
        vt[3] = '{40'h00_0000_7FFF, 24'h000000, 1'b0};
        vt[4] = '{40'h00_0000_8000, 24'h000001, 1'b0};
        vt[5] = '{40'h12_3456_789A, 24'h123456, 1'b0};
        vt[6] = '{40'hAB_CDEF_8000, 24'hABCDF0, 1'b0};
        vt[7] = '{40'h00_0000_0000, 24'h000000, 1'b0};
        vt[8] = '{40'hFF_FFFE_FFFF, 24'hFFFFFF, 1'b0};
        vt[9] = '{40'hFF_FFFF_FFFF, 24'hFFFFFF, 1'b1};

        rst     = 1'b1;
        y_valid = 1'b0;
        y_in    = '0;

        // Reset state.
        tick();
        tick();
        check("reset_outs",
              64'({sframe, sout, sfirst, sdone, ssat, y_ready}),
              64'(6'b000001));
        rst = 1'b0;
        tick();
        check("post_reset_outs",
              64'({sframe, sout, sfirst, sdone, ssat, y_ready}),
              64'(6'b000001));

        // Rounding vectors, each sent from idle.
        for (int i = 0; i < 10; i++) begin
            send(vt[i].y, cap);
            wait_rx(1, 60);
            if (rxq.size() > 0) begin
                r = rxq.pop_front();
                check($sformatf("v%0d_word", i), 64'(r.w), 64'(vt[i].w));
                check($sformatf("v%0d_sat", i), 64'(r.sat), 64'(vt[i].sat));
                check($sformatf("v%0d_frame", i), 64'(r.bad), 64'(0));
                check($sformatf("v%0d_latency", i),
                      64'(r.start - cap), 64'(1));
                check($sformatf("v%0d_len", i),
                      64'(r.done - r.start), 64'(OUT_W - 1));
            end
        end

        // Back-to-back with ready-respecting handshake.
        tick();
        tick();
        maxrun = 0;
        rxq.delete();
        y_in    = 40'h00_0001_0000;
        y_valid = 1'b1;
        k = 0;
        while (!y_ready && k < 50) begin tick(); k++; end
        tick();
        check("b2b_ready_low1", 64'(y_ready), 64'(0));
        y_in = 40'h00_0002_0000;
        k = 0;
        while (!y_ready && k < 50) begin tick(); k++; end
        tick();
        y_valid = 1'b0;
        check("b2b_ready_low2", 64'(y_ready), 64'(0));
        wait_rx(2, 100);
        if (rxq.size() >= 2) begin
            r  = rxq.pop_front();
            r2 = rxq.pop_front();
            check("b2b_word1", 64'(r.w), 64'(24'h000001));
            check("b2b_word2", 64'(r2.w), 64'(24'h000002));
            check("b2b_frames", 64'({r.bad, r2.bad}), 64'(0));
            check("b2b_gapless", 64'(r2.start - r.done), 64'(1));
        end
        tick();
        check("b2b_run", 64'(maxrun), 64'(48));

        // Backpressure: y_in changes every cycle with y_valid held.
        tick();
        tick();
        rxq.delete();
        for (int i = 0; i < 120; i++) begin
            y_in    = {16'h0, 8'(i + 1), 16'h4000};
            y_valid = 1'b1;
            if (y_ready) exp_q.push_back(i + 1);
            tick();
        end
        y_valid = 1'b0;
        wait_rx(exp_q.size(), 200);
        for (int i = 0; i < 30; i++) tick();
        check("bp_count", 64'(rxq.size()), 64'(exp_q.size()));
        nrx = (rxq.size() < exp_q.size()) ? rxq.size() : exp_q.size();
        for (int i = 0; i < nrx; i++) begin
            check($sformatf("bp_word%0d", i),
                  64'(rxq[i].w), 64'(exp_q[i]));
        end
        rxq.delete();

        // Reset mid-word with the buffer full.
        ab0 = aborted;
        send(40'h00_0055_0000, cap);
        send(40'h00_0066_0000, cap);
        k = 0;
        while (rx_bitn < 10 && k < 60) begin tick(); k++; end
        check("mid_bit10", 64'(rx_bitn >= 10), 64'(1));
        check("mid_buf_full", 64'(y_ready), 64'(0));
        rst     = 1'b1;
        y_valid = 1'b1;
        y_in    = 40'h00_0077_0000;
        tick();
        check("mid_rst_outs",
              64'({sframe, sout, sfirst, sdone, ssat, y_ready}),
              64'(6'b000001));
        rst     = 1'b0;
        y_valid = 1'b0;
        tick();
        check("mid_no_capture", 64'(y_ready), 64'(1));
        tick();
        tick();
        check("mid_no_frame", 64'(sframe), 64'(0));
        check("mid_aborted", 64'(aborted - ab0), 64'(1));
        check("mid_no_word", 64'(rxq.size()), 64'(0));
        send(40'h00_002A_8000, cap);
        wait_rx(1, 60);
        if (rxq.size() > 0) begin
            r = rxq.pop_front();
            check("mid_next_word", 64'(r.w), 64'(24'h00002B));
            check("mid_next_frame", 64'(r.bad), 64'(0));
            check("mid_next_lat", 64'(r.start - cap), 64'(1));
        end

        // Idle quiescence.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        maxrun = 0;
        idl0   = idle_bad;
        for (int i = 0; i < 100; i++) tick();
        check("idle_quiet", 64'(idle_bad - idl0), 64'(0));
        check("idle_no_frame", 64'(maxrun), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_p2s.md
# result_p2s

Output stage downstream of the divide–sine–multiply datapath. It consumes each 40-bit unsigned product and rounds it to 24 bits (round-half-up, saturating). A one-word holding buffer decouples the datapath from the serial link. Words are shifted out MSB-first on a framed serial line, and back-to-back words are sent without gaps.

## Interface
Parameters:
- IN_W, 40, product width.
- OUT_W, 24, serialized word width.
- DROP, 16, LSBs removed by rounding. Must satisfy IN_W − DROP = OUT_W.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- y_in  in  IN_W  unsigned product from the multiplier.
- y_valid  in  1  y_in is valid this cycle.
- y_ready  out  1  holding buffer empty; combinational `!hold_full`.
- sout  out  1  serial data, MSB first.
- sframe  out  1  high on every data-bit cycle of a word.
- sfirst  out  1  one-cycle pulse on bit OUT_W−1 (the first bit).
- sdone  out  1  one-cycle pulse on bit 0 (the last bit).
- ssat  out  1  current word was saturated; stable for the whole frame.

## Operation
- Rounding:
  - `r = (y_in + 2^(DROP−1)) >> DROP`, computed at IN_W+1 bits.
  - If bit IN_W of the sum is set, the word becomes all ones (0xFFFFFF) and its sat flag is set.
  - Rounding and saturation happen combinationally at capture; the buffer stores `{sat, r[OUT_W−1:0]}`.
- Capture:
  - On an edge with y_valid && y_ready, write the buffer and set hold_full.
  - y_valid with y_ready=0 is ignored. The producer must hold its data.
- FSM states: IDLE, SHIFT.
  - IDLE with hold_full: on the next edge, load the shift register and ssat from the buffer, clear hold_full, set bit counter = OUT_W−1, go to SHIFT.
  - SHIFT: sout = shreg[OUT_W−1]. Each edge shifts left one bit and decrements the counter.
  - Counter reaches 0 with hold_full: on the next edge, reload from the buffer (gapless), clear hold_full, set counter = OUT_W−1, stay in SHIFT.
  - Counter reaches 0 without hold_full: go to IDLE.
- Simultaneous events: on an edge where the buffer is unloaded into the shifter and a capture also occurs, the capture wins. hold_full stays 1 with the new word. This is only possible if y_ready was 1, so it cannot occur in the current design but must be handled.
- IDLE outputs: sout=0, sframe=0, sfirst=0, sdone=0, ssat=0.

## Timing
- Reset (asserted during any edge, mid-word included):
  - state=IDLE, hold_full=0, counter=0, shreg=0.
  - All outputs 0 except y_ready, which reads 1.
  - The word in flight is abandoned, with no partial sdone.
  - y_valid is ignored on reset edges.
- Latency: capture at edge k from IDLE puts the first bit (sframe=1, sfirst=1) on the outputs after edge k+1.
- Word duration: exactly OUT_W cycles of sframe=1.
- Back-to-back: with the buffer full at the last bit, the next word's sfirst follows sdone in the very next cycle, and sframe never drops.
- Throughput: one word per OUT_W cycles.
- y_ready falls the cycle after capture and rises the cycle after the buffer unloads into the shifter.

## Structure
- Shared package: IN_W, OUT_W, DROP constants, the FSM state enum, and the rounding offset constant 2^(DROP−1).
- Sub-module `round_sat`: combinational IN_W → {sat, OUT_W} rounder, reusable by any other consumer of the product.
- Remaining logic (buffer, shifter, counter, FSM) lives in result_p2s.

## Test plan
- Basic round: y_in=40'h00_0001_8000 captured once → 24-bit serial 0x000002, ssat=0, sfirst at capture+1, sdone 23 cycles later.
- No-saturation boundary: y_in=40'hFF_FFFF_7FFF → 0xFFFFFF with ssat=0. Then y_in=40'hFF_FFFF_8000 → 0xFFFFFF with ssat=1.
- Back-to-back: 0x0000010000 then 0x0000020000 presented while y_valid is held with ready-respecting handshake → 0x000001 then 0x000002, 48 continuous sframe cycles, y_ready low while the buffer is full.
- Backpressure: y_valid held with changing y_in while y_ready=0 → only words sampled when y_ready=1 appear serially, with none lost or duplicated.
- Reset mid-word: assert rst at bit 10 of a word with the buffer full → all outputs 0 the following cycle, no sdone, y_ready=1. The next capture starts a clean frame.
- Idle quiescence: after reset with no y_valid for 100 cycles → sframe, sout, sfirst, sdone and ssat stay 0.
